pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Consumer end of the next-PC path: holds the architectural PC register and loads it from the combinational next-PC result.
- Drives instruction-memory fetch requests with a req/gnt/rsp handshake and presents each fetched instruction to decode with a valid/ready handshake.
- Sits between the next-PC logic, the instruction memory and the decode stage, and turns the single-cycle datapath into a handshaked fetch loop.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before fault. Used only with the optional feature. Must be at least 1.

Ports:
- CLK  in  1  clock. All state is updated on the rising edge.
- resetl  in  1  asynchronous active-low reset.
- NextPC  in  64  next PC from the next-PC logic.
- NextPCValid  in  1  execute has finished the current instruction; NextPC is final.
- CurrentPC  out  64  architectural PC, fed back to the next-PC logic.
- IMemReq  out  1  fetch request.
- IMemAddr  out  64  fetch address; always equals CurrentPC.
- IMemGnt  in  1  imem accepts the request.
- IMemRspValid  in  1  fetch data valid.
- IMemRspData  in  32  fetched instruction word.
- Instruction  out  32  registered instruction to decode.
- InstrValid  out  1  Instruction is valid.
- InstrReady  in  1  decode accepts Instruction.
- Fault  out  1  sticky fault (misaligned NextPC, or timeout when the feature is enabled).

Behaviour:
- Reset (resetl=0, asynchronous):
  - CurrentPC=RESET_PC, Instruction=0, InstrValid=0, IMemReq=0, Fault=0, state=REQ.
  - Outputs drop immediately, including in the middle of a transaction; any in-flight response is discarded.
- States: REQ, WAIT, HOLD, EXEC, FAULT. Outputs are decoded from registered state only.
- REQ:
  - IMemReq=1, IMemAddr=CurrentPC.
  - Request is held stable until IMemGnt=1 is sampled, then go to WAIT.
  - First request appears in the first cycle after resetl rises.
- WAIT:
  - IMemReq=0.
  - On IMemRspValid=1: Instruction<=IMemRspData, InstrValid<=1, go to HOLD.
  - Earliest response is the cycle after the grant. IMemRspValid is ignored in every state except WAIT.
- HOLD:
  - InstrValid=1; Instruction is held stable.
  - On InstrReady=1: InstrValid<=0, go to EXEC.
  - Minimum latency from grant to decode handshake is 2 cycles.
- EXEC:
  - Wait for NextPCValid=1.
  - If NextPC[1:0]==0: CurrentPC<=NextPC, go to REQ.
  - Otherwise: CurrentPC unchanged, Fault<=1, go to FAULT.
  - NextPCValid is ignored in every state except EXEC.
- FAULT:
  - Terminal. IMemReq=0, InstrValid=0, Fault=1 until reset.
- Arithmetic:
  - No arithmetic in this block; NextPC is taken verbatim.
  - 64-bit wrap-around is the next-PC logic's responsibility. For example, NextPC=64'hFFFF_FFFF_FFFF_FFFC is loaded as-is.
- Fetch throughput: one instruction in flight at most. No speculative next fetch is issued.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle spent in WAIT without IMemRspValid.
  - When the count reaches TIMEOUT_CYCLES: Fault<=1, go to FAULT.
  - A response arriving in the same cycle the count reaches TIMEOUT_CYCLES wins; it is accepted normally with no fault.
- Undefined:
  - No counter exists and WAIT waits indefinitely.
  - Fault is set only by a misaligned NextPC.

Test Plan:
- Reset and first fetch: RESET_PC=64'h100; release resetl -> next cycle IMemReq=1 with IMemAddr=64'h100; Fault=0; InstrValid=0.
- Basic loop: gnt on cycle 1, rsp 32'hD2800020 on cycle 2, InstrReady=1, NextPC=64'h104 with NextPCValid -> InstrValid=1 for exactly one cycle with Instruction=32'hD2800020; next request is at 64'h104.
- Backpressure: hold InstrReady=0 for 5 cycles and pulse IMemRspValid with 32'hDEADBEEF during HOLD -> Instruction stays equal to the first word and no new IMemReq is issued. Asserting NextPCValid during HOLD is ignored.
- Branch and misalignment:
  - NextPC=64'h40 (branch target) -> next IMemAddr=64'h40.
  - Then NextPC=64'h46 -> Fault=1, IMemReq stays 0, CurrentPC stays 64'h40.
- Reset mid-transaction: drop resetl while in WAIT -> IMemReq, InstrValid and Fault go to 0 without waiting for a clock; a late IMemRspValid is ignored; after release, fetch restarts at RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - No response for 16 WAIT cycles -> Fault=1.
  - Response on the 16th cycle -> accepted normally, Fault=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC register and handshaked fetch loop (imem req/gnt/rsp -> decode valid/ready).
// Optional WAIT-state response timeout is enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl #(
  parameter logic [63:0] RESET_PC       = 64'h0000_0000_0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] NextPC,
  input  logic        NextPCValid,
  output logic [63:0] CurrentPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        Fault
);

  // state | meaning
  // REQ   | fetch request at CurrentPC held until granted
  // WAIT  | granted, waiting for the instruction word
  // HOLD  | instruction presented to decode until accepted
  // EXEC  | waiting for execute to deliver the next PC
  // FAULT | terminal: misaligned next PC or fetch timeout
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_armed;
  logic [63:0] r_pc;
  logic [31:0] r_instr;

  logic        w_req;
  logic        w_valid;
  logic        w_fault;
  logic        w_grant;
  logic        w_rsp_take;
  logic        w_pc_take;
  logic        w_misalign;
  logic        w_timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("pc_fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  // The request only appears once the first clock edge after reset release has armed the fetch loop.
  assign w_grant    = (r_state == S_REQ) && r_armed && IMemGnt;
  assign w_rsp_take = (r_state == S_WAIT) && IMemRspValid;
  assign w_misalign = |NextPC[1:0];
  assign w_pc_take  = (r_state == S_EXEC) && NextPCValid && !w_misalign;

`ifdef FETCH_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Down-counter loaded on grant; terminal count in WAIT without a response is the timeout.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_wait_cnt <= '0;
    end else if (w_grant) begin
      r_wait_cnt <= CNT_LOAD;
    end else if ((r_state == S_WAIT) && !IMemRspValid && (r_wait_cnt != '0)) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !IMemRspValid && (r_wait_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_grant) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (IMemRspValid)   w_state_nxt = S_HOLD;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_HOLD: begin
        if (InstrReady) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (NextPCValid) w_state_nxt = w_misalign ? S_FAULT : S_REQ;
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_valid = 1'b0;
    w_fault = 1'b0;
    case (r_state)
      S_REQ:   w_req   = r_armed;
      S_HOLD:  w_valid = 1'b1;
      S_FAULT: w_fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_pc <= RESET_PC;
    end else if (w_pc_take) begin
      r_pc <= NextPC;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_instr <= 32'h0;
    end else if (w_rsp_take) begin
      r_instr <= IMemRspData;
    end
  end

  assign CurrentPC   = r_pc;
  assign IMemAddr    = r_pc;
  assign IMemReq     = w_req;
  assign Instruction = r_instr;
  assign InstrValid  = w_valid;
  assign Fault       = w_fault;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: driver pushes expected fetch addresses / instruction words,
// a negedge monitor pops and compares on each grant and decode handshake.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam int          TO     = 16;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic [63:0] NextPC = '0;
  logic        NextPCValid = 1'b0;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemGnt = 1'b0;
  logic        IMemRspValid = 1'b0;
  logic [31:0] IMemRspData = '0;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        Fault;

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .resetl(resetl), .NextPC(NextPC), .NextPCValid(NextPCValid),
    .CurrentPC(CurrentPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData), .Instruction(Instruction),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_err = 0;
  logic [63:0] q_addr[$];
  logic [31:0] q_instr[$];
  bit          mon_en = 1'b0;
  logic [63:0] mon_addr;
  logic [31:0] mon_instr;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk64(name, {32'h0, act}, {32'h0, exp});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk64(name, {63'h0, act}, {63'h0, exp});
  endtask

  // Monitor: every grant consumes one expected fetch address, every decode handshake one word.
  always @(negedge CLK) begin
    if (mon_en && resetl) begin
      if (IMemReq && IMemGnt) begin
        chk1("fetch_expected", q_addr.size() != 0, 1'b1);
        if (q_addr.size() != 0) begin
          mon_addr = q_addr.pop_front();
          chk64("fetch_addr", IMemAddr, mon_addr);
          chk64("current_pc", CurrentPC, mon_addr);
        end
      end
      if (InstrValid && InstrReady) begin
        chk1("instr_expected", q_instr.size() != 0, 1'b1);
        if (q_instr.size() != 0) begin
          mon_instr = q_instr.pop_front();
          chk32("instr_word", Instruction, mon_instr);
        end
        chk1("no_req_in_hold", IMemReq, 1'b0);
        chk1("no_fault_in_hold", Fault, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    IMemGnt      = 1'b0;
    IMemRspValid = 1'b0;
    InstrReady   = 1'b0;
    NextPCValid  = 1'b0;
  endtask

  // One fetch/decode/execute round: gd grant delay, rd response delay, yd decode stall, pd execute delay.
  task automatic do_txn(input logic [31:0] word, input logic [63:0] npc,
                        input int gd, input int rd, input int yd, input int pd, input bit junk);
    int budget;
    budget = 0;
    while (!IMemReq && budget < 10) begin
      step();
      budget++;
    end
    chk1("req_seen", IMemReq, 1'b1);
    if (!IMemReq) return;
    for (int i = 0; i < gd; i++) begin
      IMemGnt      = 1'b0;
      IMemRspValid = junk && ($urandom_range(1, 0) == 1);
      IMemRspData  = $urandom;
      NextPCValid  = junk && ($urandom_range(1, 0) == 1);
      NextPC       = {$urandom, $urandom};
      step();
      chk1("req_held", IMemReq, 1'b1);
    end
    idle_inputs();
    IMemGnt = 1'b1;
    step();
    IMemGnt = 1'b0;
    chk1("wait_no_req", IMemReq, 1'b0);
    for (int i = 0; i < rd; i++) begin
      IMemGnt     = junk && ($urandom_range(1, 0) == 1);
      NextPCValid = junk && ($urandom_range(1, 0) == 1);
      NextPC      = {$urandom, $urandom};
      step();
      chk1("wait_no_valid", InstrValid, 1'b0);
    end
    idle_inputs();
    IMemRspValid = 1'b1;
    IMemRspData  = word;
    q_instr.push_back(word);
    step();
    IMemRspValid = 1'b0;
    chk1("rsp_to_valid", InstrValid, 1'b1);
    for (int i = 0; i < yd; i++) begin
      InstrReady   = 1'b0;
      IMemRspValid = junk && (i == 0 || $urandom_range(1, 0) == 1);
      IMemRspData  = (i == 0) ? 32'hDEADBEEF : $urandom;
      IMemGnt      = junk && ($urandom_range(1, 0) == 1);
      NextPCValid  = junk && (i == 1 || $urandom_range(1, 0) == 1);
      NextPC       = {$urandom, $urandom};
      step();
      chk1("hold_valid", InstrValid, 1'b1);
      chk32("hold_instr_stable", Instruction, word);
      chk1("hold_no_req", IMemReq, 1'b0);
    end
    idle_inputs();
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    chk1("valid_one_shot", InstrValid, 1'b0);
    for (int i = 0; i < pd; i++) begin
      IMemRspValid = junk && ($urandom_range(1, 0) == 1);
      IMemRspData  = $urandom;
      IMemGnt      = junk && ($urandom_range(1, 0) == 1);
      step();
      chk1("exec_no_req", IMemReq, 1'b0);
    end
    idle_inputs();
    NextPC      = npc;
    NextPCValid = 1'b1;
    if (npc[1:0] == 2'b00) q_addr.push_back(npc);
    step();
    NextPCValid = 1'b0;
  endtask

  task automatic assert_reset_mid(input string tag);
    #2;
    resetl = 1'b0;
    mon_en = 1'b0;
    #1;
    chk1({tag, "_req_async"}, IMemReq, 1'b0);
    chk1({tag, "_valid_async"}, InstrValid, 1'b0);
    chk1({tag, "_fault_async"}, Fault, 1'b0);
    chk64({tag, "_pc_async"}, CurrentPC, RST_PC);
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1;
    resetl = 1'b1;
    q_addr.delete();
    q_instr.delete();
    q_addr.push_back(RST_PC);
    mon_en = 1'b1;
    step();
    IMemRspValid = 1'b0;
    chk1("rst_first_req", IMemReq, 1'b1);
    chk64("rst_first_addr", IMemAddr, RST_PC);
    chk1("rst_fault", Fault, 1'b0);
    chk1("rst_valid", InstrValid, 1'b0);
    chk32("rst_instr", Instruction, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] npc;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    chk1("in_reset_req", IMemReq, 1'b0);
    chk1("in_reset_valid", InstrValid, 1'b0);
    chk1("in_reset_fault", Fault, 1'b0);
    chk64("in_reset_pc", CurrentPC, RST_PC);
    release_reset();

    // Basic loop, then decode backpressure with a stray response and stray NextPCValid, branch to 0x40.
    do_txn(32'hD2800020, 64'h104, 0, 0, 0, 0, 1'b0);
    do_txn(32'h8B010000, 64'h40, 1, 2, 5, 2, 1'b1);

    for (int t = 0; t < 25; t++) begin
      npc = {$urandom, $urandom} & ~64'h3;
      if (t == 7) npc = 64'hFFFF_FFFF_FFFF_FFFC;
      do_txn($urandom, npc, $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(4, 0), $urandom_range(3, 0), 1'b1);
    end

    // Branch to 0x40 then a misaligned target.
    do_txn($urandom, 64'h40, 0, 1, 0, 0, 1'b1);
    do_txn($urandom, 64'h46, 0, 0, 1, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk1("fault_set", Fault, 1'b1);
      chk1("fault_no_req", IMemReq, 1'b0);
      chk1("fault_no_valid", InstrValid, 1'b0);
      chk64("fault_pc_kept", CurrentPC, 64'h40);
      IMemGnt      = 1'b1;
      IMemRspValid = 1'b1;
      NextPC       = 64'h200;
      NextPCValid  = 1'b1;
      step();
      idle_inputs();
    end
    chk32("addr_q_drained_fault", q_addr.size(), 0);

    // Reset out of FAULT, then reset while HOLD presents a word.
    assert_reset_mid("rst_fault");
    release_reset();
    IMemGnt = 1'b1;
    step();
    idle_inputs();
    IMemRspValid = 1'b1;
    IMemRspData  = 32'h12345678;
    step();
    IMemRspValid = 1'b0;
    chk1("pre_rst_hold_valid", InstrValid, 1'b1);
    assert_reset_mid("rst_hold");
    chk32("rst_hold_instr_async", Instruction, 32'h0);
    release_reset();

    // Reset while in WAIT with a late response arriving during and after reset.
    IMemGnt = 1'b1;
    step();
    IMemGnt = 1'b0;
    assert_reset_mid("rst_wait");
    IMemRspValid = 1'b1;
    IMemRspData  = 32'hCAFEF00D;
    release_reset();
    do_txn(32'hA0B0C0D0, 64'h1000, 0, 1, 1, 0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    IMemGnt = 1'b1;
    step();
    IMemGnt = 1'b0;
    repeat (TO - 1) step();
    chk1("timeout_not_yet", Fault, 1'b0);
    step();
    chk1("timeout_fault", Fault, 1'b1);
    chk1("timeout_no_req", IMemReq, 1'b0);
    assert_reset_mid("rst_timeout");
    release_reset();
    do_txn(32'h0F0F0F0F, 64'h2000, 0, TO - 1, 0, 0, 1'b0);
    chk1("late_rsp_no_fault", Fault, 1'b0);
`endif

    IMemGnt = 1'b1;
    step();
    IMemGnt = 1'b0;
    step();
    chk32("addr_q_drained", q_addr.size(), 0);
    chk32("instr_q_drained", q_instr.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
